// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: ID-stage load-use/legacy hazard detection, registered EXE forwarding selects, and a saturating stall counter.
// Port summary:
//   clk, rst                  clock and synchronous active-high reset
//   fwd_en                    1 = forwarding mode, 0 = legacy stall-only mode
//   src_addr, src_valid       ID source registers and their read enables, NUM_SRC channels
//   wb_en_exe, mem_r_en_exe,
//   dest_exe                  producer in EXE
//   wb_en_mem, dest_mem       producer in MEM
//   mem_ready                 0 freezes the pipeline
//   flush                     taken branch squashes the ID instruction
//   hazard                    combinational stall request
//   fwd_sel                   registered per-channel EXE operand select: 00 RF, 01 MEM ALU, 10 WB
//   stall_cnt                 saturating count of non-frozen stall cycles
module hazard_forward_unit #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fwd_en,
  input  logic [NUM_SRC*REG_AW-1:0]   src_addr,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic                        wb_en_exe,
  input  logic                        mem_r_en_exe,
  input  logic [REG_AW-1:0]           dest_exe,
  input  logic                        wb_en_mem,
  input  logic [REG_AW-1:0]           dest_mem,
  input  logic                        mem_ready,
  input  logic                        flush,
  output logic                        hazard,
  output logic [2*NUM_SRC-1:0]        fwd_sel,
  output logic [CNT_W-1:0]            stall_cnt
);
  logic [NUM_SRC-1:0]   m_e, m_m;
  logic [2*NUM_SRC-1:0] nsel, fwd_sel_d, fwd_sel_q;
  logic [CNT_W-1:0]     stall_cnt_d, stall_cnt_q;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_ch
    assign m_e[i] = src_valid[i] & wb_en_exe & (src_addr[i*REG_AW +: REG_AW] == dest_exe);
    assign m_m[i] = src_valid[i] & wb_en_mem & (src_addr[i*REG_AW +: REG_AW] == dest_mem);
    // The EXE producer is younger, so it wins when both stages match.
    assign nsel[2*i +: 2] = !fwd_en ? 2'b00 : m_e[i] ? 2'b01 : m_m[i] ? 2'b10 : 2'b00;
  end
  // With forwarding only a load in EXE cannot be bypassed; legacy mode stalls on any match.
  assign hazard = !rst && !flush && (fwd_en ? (|m_e && mem_r_en_exe) : |(m_e | m_m));
  always_comb begin
    fwd_sel_d   = !mem_ready ? fwd_sel_q : (flush || hazard) ? '0 : nsel;
    stall_cnt_d = (hazard && mem_ready && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_sel_q   <= fwd_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign fwd_sel   = fwd_sel_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed bench with a per-cycle reference model and literal spot checks.
module tb_hazard_forward_unit;
  logic        clk = 0, rst = 1, fwd_en = 1;
  logic [7:0]  src_addr = 0;
  logic [1:0]  src_valid = 0;
  logic        wb_en_exe = 0, mem_r_en_exe = 0, wb_en_mem = 0, mem_ready = 1, flush = 0;
  logic [3:0]  dest_exe = 0, dest_mem = 0;
  logic        hazard, hazard2;
  logic [3:0]  fwd_sel, fwd_sel2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;
  int checks = 0, errors = 0;
  int m_sel = 0, m_cnt = 0, m_cnt2 = 0;
  bit armed = 0;

  hazard_forward_unit dut (.clk(clk), .rst(rst), .fwd_en(fwd_en), .src_addr(src_addr), .src_valid(src_valid),
    .wb_en_exe(wb_en_exe), .mem_r_en_exe(mem_r_en_exe), .dest_exe(dest_exe), .wb_en_mem(wb_en_mem),
    .dest_mem(dest_mem), .mem_ready(mem_ready), .flush(flush), .hazard(hazard), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt));
  hazard_forward_unit #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .fwd_en(fwd_en), .src_addr(src_addr), .src_valid(src_valid),
    .wb_en_exe(wb_en_exe), .mem_r_en_exe(mem_r_en_exe), .dest_exe(dest_exe), .wb_en_mem(wb_en_mem),
    .dest_mem(dest_mem), .mem_ready(mem_ready), .flush(flush), .hazard(hazard2), .fwd_sel(fwd_sel2), .stall_cnt(stall_cnt2));

  always #5 clk = ~clk;

  function automatic bit match_exe(int c);
    int s = int'((src_addr >> (4 * c)) & 8'hF);
    return src_valid[c] && wb_en_exe && s == int'(dest_exe);
  endfunction
  function automatic bit match_mem(int c);
    int s = int'((src_addr >> (4 * c)) & 8'hF);
    return src_valid[c] && wb_en_mem && s == int'(dest_mem);
  endfunction
  function automatic bit exp_hazard();
    bit any = 0, load_use = 0;
    for (int c = 0; c < 2; c++) begin
      if (match_exe(c) || match_mem(c)) any = 1;
      if (match_exe(c) && mem_r_en_exe) load_use = 1;
    end
    if (rst || flush) return 0;
    return fwd_en ? load_use : any;
  endfunction
  function automatic int exp_nsel();
    int r = 0;
    for (int c = 0; c < 2; c++)
      if (fwd_en) r += (match_exe(c) ? 1 : match_mem(c) ? 2 : 0) * (4 ** c);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_sel <= 0; m_cnt <= 0; m_cnt2 <= 0; armed <= 1;
    end else if (mem_ready) begin
      m_sel <= (exp_hazard() || flush) ? 0 : exp_nsel();
      if (exp_hazard()) begin
        m_cnt  <= m_cnt < 65535 ? m_cnt + 1 : m_cnt;
        m_cnt2 <= m_cnt2 < 3 ? m_cnt2 + 1 : m_cnt2;
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (armed) begin
    chk("model_hazard", int'(hazard), int'(exp_hazard()));
    chk("model_hazard_w2", int'(hazard2), int'(exp_hazard()));
    chk("model_fwd_sel", int'(fwd_sel), m_sel);
    chk("model_fwd_sel_w2", int'(fwd_sel2), m_sel);
    chk("model_stall_cnt", int'(stall_cnt), m_cnt);
    chk("model_stall_cnt_w2", int'(stall_cnt2), m_cnt2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with live matches
    src_addr = {4'd5, 4'd3}; src_valid = 2'b11; wb_en_exe = 1; dest_exe = 3; mem_r_en_exe = 1;
    tick(); tick();
    chk("reset_hazard", int'(hazard), 0);
    chk("reset_fwd_sel", int'(fwd_sel), 0);
    chk("reset_cnt", int'(stall_cnt), 0);
    rst = 0; wb_en_exe = 0; mem_r_en_exe = 0;
    tick();
    chk("idle_fwd_sel", int'(fwd_sel), 0);
    chk("idle_cnt", int'(stall_cnt), 0);
    // ALU forwarding from EXE, then EXE priority over MEM
    src_valid = 2'b01; wb_en_exe = 1; dest_exe = 3;
    #1 chk("alu_hazard", int'(hazard), 0);
    tick();
    chk("alu_fwd_sel", int'(fwd_sel), 4'b0001);
    wb_en_mem = 1; dest_mem = 3;
    tick();
    chk("exe_priority", int'(fwd_sel), 4'b0001);
    src_valid = 2'b11; dest_mem = 5;
    tick();
    chk("two_channel", int'(fwd_sel), 4'b1001);
    // Load-use: one stall, then WB forwarding on channel 1
    src_valid = 2'b10; dest_exe = 5; mem_r_en_exe = 1; wb_en_mem = 0;
    #1 chk("lu_hazard", int'(hazard), 1);
    tick();
    chk("lu_bubble", int'(fwd_sel), 0);
    chk("lu_cnt", int'(stall_cnt), 1);
    wb_en_exe = 0; mem_r_en_exe = 0; wb_en_mem = 1; dest_mem = 5;
    #1 chk("lu_resolved", int'(hazard), 0);
    tick();
    chk("lu_fwd_wb", int'(fwd_sel), 4'b1000);
    // Legacy mode
    fwd_en = 0; src_addr = {4'd5, 4'd2}; src_valid = 2'b01; dest_mem = 2;
    #1 chk("legacy_hazard", int'(hazard), 1);
    tick();
    chk("legacy_fwd_sel", int'(fwd_sel), 0);
    chk("legacy_cnt", int'(stall_cnt), 2);
    src_valid = 2'b00;
    #1 chk("invalid_src", int'(hazard), 0);
    tick();
    // Freeze and flush
    fwd_en = 1; src_addr = {4'd5, 4'd3}; src_valid = 2'b01; wb_en_exe = 1; dest_exe = 3; wb_en_mem = 0;
    tick();
    chk("pre_freeze", int'(fwd_sel), 4'b0001);
    mem_r_en_exe = 1; mem_ready = 0;
    tick(); tick(); tick();
    chk("freeze_hold", int'(fwd_sel), 4'b0001);
    chk("freeze_cnt", int'(stall_cnt), 2);
    mem_ready = 1; flush = 1;
    #1 chk("flush_hazard", int'(hazard), 0);
    tick();
    chk("flush_fwd_sel", int'(fwd_sel), 0);
    chk("flush_cnt", int'(stall_cnt), 2);
    flush = 0;
    // Saturation of the 2-bit counter
    rst = 1; tick(); rst = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("sat_cnt_w2", int'(stall_cnt2), k < 3 ? k + 1 : 3);
    end
    chk("sat_cnt_w16", int'(stall_cnt), 5);
    // Reset mid-stall
    rst = 1;
    #1 chk("rst_mid_hazard", int'(hazard), 0);
    tick();
    chk("rst_mid_cnt", int'(stall_cnt), 0);
    rst = 0; mem_r_en_exe = 0;
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised next-generation hazard detection and forwarding control for the ARM pipeline.
- Sits in the ID stage. Compares ID source registers against the destinations of the instructions in EXE and MEM.
- Raises a stall only when forwarding cannot resolve the dependency: load-use, or forwarding disabled.
- Otherwise computes per-source forwarding selects. These are registered into the ID/EXE boundary and drive the EXE operand muxes.
- Also tracks pipeline freeze (memory not ready), branch flush, and a saturating stall-cycle counter for performance monitoring.

Parameters:
REG_AW, 4, register address width.
NUM_SRC, 2, number of source operand channels checked per instruction.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  clock. Single clock domain; reset is synchronous and active-high.
rst  in  1  synchronous active-high reset.
fwd_en  in  1  runtime mode. 1 = forwarding enabled; 0 = stall-only mode, matching the legacy hazard behaviour.
src_addr  in  NUM_SRC*REG_AW  ID source register numbers; channel i at bits [i*REG_AW +: REG_AW].
src_valid  in  NUM_SRC  per-channel "source is actually read" (generalises Two_Src).
wb_en_exe  in  1  instruction in EXE writes back.
mem_r_en_exe  in  1  instruction in EXE is a load.
dest_exe  in  REG_AW  EXE destination register.
wb_en_mem  in  1  instruction in MEM writes back.
dest_mem  in  REG_AW  MEM destination register.
mem_ready  in  1  memory stage ready. 0 freezes the whole pipeline.
flush  in  1  taken branch; the instruction in ID is squashed.
hazard  out  1  stall IF/ID and insert a bubble into EXE (combinational).
fwd_sel  out  2*NUM_SRC  registered per-channel EXE mux select: 00 register file, 01 MEM-stage ALU result, 10 WB result, 11 unused.
stall_cnt  out  CNT_W  cycles in which hazard=1 and mem_ready=1; saturating.

Behaviour:
- Reset (rst=1 at posedge clk): fwd_sel <= 0, stall_cnt <= 0. hazard is forced to 0 while rst=1.
- Match terms, per channel i:
  - mE[i] = src_valid[i] & wb_en_exe & (src_i == dest_exe)
  - mM[i] = src_valid[i] & wb_en_mem & (src_i == dest_mem)
- hazard, combinational, same cycle:
  - fwd_en=0: hazard = OR over i of (mE[i] | mM[i]).
  - fwd_en=1: hazard = OR over i of (mE[i] & mem_r_en_exe) (load-use only).
  - flush=1 forces hazard=0.
- Next select, per channel, fwd_en=1:
  - nsel = 01 if mE[i]; else 10 if mM[i]; else 00.
  - EXE has priority: when both match, the youngest producer wins.
  - Rationale: on advance, the EXE producer moves to MEM and the MEM producer moves to WB.
- Next select, fwd_en=0: nsel = 00 for all channels.
- fwd_sel register update, per posedge clk, priority order:
  1. rst → 0.
  2. mem_ready=0 → hold (freeze; the EXE instruction does not change).
  3. flush=1 or hazard=1 → 0 (a bubble enters EXE).
  4. Otherwise → nsel for all channels.
- Load-use resolution:
  - Cycle t: load in EXE, consumer in ID → hazard=1, bubble.
  - Cycle t+1: load in MEM, mE=0, mM=1 → hazard=0; fwd_sel becomes 10 at the end of t+1.
  - Exactly 1 stall cycle per load-use when mem_ready stays 1.
- stall_cnt increments when hazard=1 & mem_ready=1 & rst=0. It holds at 2^CNT_W-1 (no wrap).
- Freeze cycles (mem_ready=0) are not counted and do not change fwd_sel, even if hazard=1.
- Channels with src_valid=0 never generate matches.
- Register 15 (PC) receives no special treatment.
- Simultaneous flush and hazard: flush wins; hazard=0 and fwd_sel <= 0.
- Reset mid-stall: hazard drops to 0 immediately, and registers clear on the same edge.
- Implementation: generate loop over NUM_SRC. No latches; all registers on posedge clk.

Test Plan:
1. Reset: rst=1 for 2 cycles with active matches → hazard=0, fwd_sel=0000, stall_cnt=0. After release with no matches, outputs stay 0.
2. ALU forwarding: fwd_en=1, src0=3, src_valid=01, wb_en_exe=1, dest_exe=3, mem_r_en_exe=0 → hazard=0; next cycle fwd_sel=0001. With dest_mem=3 also matching → still 01 (EXE priority).
3. Load-use: fwd_en=1, src1=5 valid, load in EXE with dest 5 → hazard=1 for 1 cycle, stall_cnt=1. Next cycle, dest_mem=5 → hazard=0, then fwd_sel[3:2]=10.
4. Legacy mode: fwd_en=0, src0=2 matches dest_mem=2 → hazard=1, fwd_sel stays 0000. src_valid=0 with the same addresses → hazard=0.
5. Freeze/flush: fwd_sel=0001, mem_ready=0 for 3 cycles with a load-use condition → fwd_sel holds 0001, stall_cnt unchanged. flush=1 with a load-use condition → hazard=0, fwd_sel <= 0000.
6. Saturation: CNT_W=2, hazard held for 5 active cycles → stall_cnt reads 1,2,3,3,3.
